// File: rtl/thr_pkg.sv
// Shared constants and width helpers for the
// threshold / binarization blocks.
package thr_pkg;

  localparam int THR_W   = 8;
  localparam int LUMA_SH = 8;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  function automatic int pix_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  function automatic int sum_w(input int h, input int v);
    return THR_W + pix_w(h, v);
  endfunction

endpackage

// File: rtl/div_seq_u.sv
// Unsigned restoring divider, one quotient bit
// per cycle; N_W cycles from start to done.
module div_seq_u #(
  parameter int N_W = 25,
  parameter int D_W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int C_W = $clog2(N_W + 1);

  logic [D_W-1:0] rem;
  logic [D_W-1:0] dvs;
  logic [N_W-1:0] quo;
  logic [C_W-1:0] cnt;
  logic [D_W:0]   trial;
  logic [D_W:0]   diff;
  logic           ge;

  // shift next dividend bit into the partial remainder
  assign trial = {rem, quo[N_W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = trial >= {1'b0, dvs};

  // load on start when idle, then iterate N_W times
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem <= ge ? diff[D_W-1:0] : trial[D_W-1:0];
        quo <= {quo[N_W-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == C_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        rem  <= '0;
        dvs  <= divisor;
        quo  <= dividend;
        cnt  <= C_W'(N_W);
        busy <= 1'b1;
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/thr_binarize_mean.sv
// RGB888 to 1-bit binarizer; threshold is the
// previous frame's mean luma or a manual value.
module thr_binarize_mean
  import thr_pkg::*;
#(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int THR_INIT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic             in_de,
  input  logic [23:0]      in_data,
  input  logic             thr_mode,
  input  logic [THR_W-1:0] thr_manual,
  output logic             out_hs,
  output logic             out_vs,
  output logic             out_de,
  output logic             out_data,
  output logic [THR_W-1:0] thr_value
);

  localparam int PIX_W = pix_w(H_ACTIVE, V_ACTIVE);
  localparam int SUM_W = sum_w(H_ACTIVE, V_ACTIVE);

  logic [2:0]       tim_d1, tim_d2, tim_d3;
  logic [15:0]      r_p, g_p, b_p;
  logic [15:0]      luma_sum;
  logic [THR_W-1:0] y_s2;
  logic [THR_W-1:0] thr_eff;
  logic [THR_W-1:0] thr_active;
  logic [THR_W-1:0] thr_next;
  logic [THR_W-1:0] q_clip;
  logic             thr_vld;
  logic             armed;
  logic             bin_q;
  logic             vs_rise, vs_in_rise, de_rise;
  logic [SUM_W-1:0] acc_sum;
  logic [PIX_W-1:0] pix_cnt;
  logic             sat;
  logic             div_go, div_busy, div_done;
  logic [SUM_W-1:0] div_num, div_q;
  logic [PIX_W-1:0] div_den;

  assign luma_sum   = r_p + g_p + b_p;
  assign thr_eff    = thr_mode ? thr_manual : thr_active;
  assign vs_rise    = tim_d2[1] & ~tim_d3[1];
  assign vs_in_rise = in_vs & ~tim_d1[1];
  assign de_rise    = in_de & ~tim_d1[0];
  assign q_clip     = (|div_q[SUM_W-1:THR_W]) ?
                      '1 : div_q[THR_W-1:0];

  // three-stage luma / compare pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_d1 <= '0;
      tim_d2 <= '0;
      tim_d3 <= '0;
      r_p    <= '0;
      g_p    <= '0;
      b_p    <= '0;
      y_s2   <= '0;
      bin_q  <= 1'b0;
    end else begin
      tim_d1 <= {in_hs, in_vs, in_de};
      tim_d2 <= tim_d1;
      tim_d3 <= tim_d2;
      r_p    <= 16'(in_data[23:16]) * 16'(COEF_R);
      g_p    <= 16'(in_data[15:8]) * 16'(COEF_G);
      b_p    <= 16'(in_data[7:0]) * 16'(COEF_B);
      y_s2   <= THR_W'(luma_sum >> LUMA_SH);
      bin_q  <= y_s2 > thr_eff;
    end
  end

  // frame luma sum; hand off to divider at VS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      pix_cnt <= '0;
      sat     <= 1'b0;
      div_go  <= 1'b0;
      div_num <= '0;
      div_den <= '0;
    end else begin
      div_go <= 1'b0;
      if (vs_rise) begin
        if (pix_cnt != '0 && !sat && !div_busy) begin
          div_go  <= 1'b1;
          div_num <= acc_sum;
          div_den <= pix_cnt;
        end
        acc_sum <= '0;
        pix_cnt <= '0;
        sat     <= 1'b0;
      end else if (tim_d2[0]) begin
        if (&pix_cnt) begin
          sat <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
          acc_sum <= acc_sum + SUM_W'(y_s2);
        end
      end
    end
  end

  div_seq_u #(
    .N_W(SUM_W),
    .D_W(PIX_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go),
    .dividend (div_num),
    .divisor  (div_den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // swap in a finished mean at the first DE of a frame;
  // a result landing in the same cycle stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_next   <= '0;
      thr_vld    <= 1'b0;
      armed      <= 1'b0;
      thr_active <= THR_W'(THR_INIT);
    end else begin
      if (vs_in_rise) begin
        armed <= 1'b1;
      end else if (de_rise && armed) begin
        armed <= 1'b0;
        if (thr_vld) begin
          thr_active <= thr_next;
          thr_vld    <= 1'b0;
        end
      end
      if (div_done) begin
        thr_next <= q_clip;
        thr_vld  <= 1'b1;
      end
    end
  end

  assign out_hs    = tim_d3[2];
  assign out_vs    = tim_d3[1];
  assign out_de    = tim_d3[0];
  assign out_data  = bin_q;
  assign thr_value = thr_active;

endmodule

// File: tb/tb_thr_binarize_mean.sv
// Directed bench for thr_binarize_mean: frame
// sequences with hand-computed thresholds.
module tb_thr_binarize_mean;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_hs, in_vs, in_de;
  logic [23:0] in_data;
  logic       thr_mode;
  logic [7:0] thr_manual;
  logic       out_hs, out_vs, out_de, out_data;
  logic [7:0] thr_value;

  int n_run  = 0;
  int n_fail = 0;

  logic cur_chk, cur_exp;

  typedef struct packed {
    logic hs, vs, de, chk, exp_b, v;
  } hist_t;

  hist_t h1, h2, h3;

  typedef struct {
    logic [7:0] g;
    logic       mode;
    logic [7:0] man;
    logic       exp_b;
  } vec_t;

  vec_t tv [12];

  always #5 clk = ~clk;

  thr_binarize_mean #(
    .H_ACTIVE(480),
    .V_ACTIVE(272),
    .THR_INIT(128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_hs      (in_hs),
    .in_vs      (in_vs),
    .in_de      (in_de),
    .in_data    (in_data),
    .thr_mode   (thr_mode),
    .thr_manual (thr_manual),
    .out_hs     (out_hs),
    .out_vs     (out_vs),
    .out_de     (out_de),
    .out_data   (out_data),
    .thr_value  (thr_value)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_run++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp_v);
    end
  endtask

  // expected outputs: inputs delayed by 3 clocks
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else begin
      h1 <= {in_hs, in_vs, in_de, cur_chk, cur_exp, 1'b1};
      h2 <= h1;
      h3 <= h2;
    end
  end

  always @(negedge clk) begin
    if (!rst && h3.v) begin
      check("out_hs", out_hs, h3.hs);
      check("out_vs", out_vs, h3.vs);
      check("out_de", out_de, h3.de);
      if (h3.chk) check("out_data", out_data, h3.exp_b);
    end
  end

  task automatic cyc(input logic hs, input logic vs,
                     input logic de, input logic [7:0] g,
                     input logic chk, input logic eb);
    in_hs   = hs;
    in_vs   = vs;
    in_de   = de;
    in_data = {g, g, g};
    cur_chk = chk;
    cur_exp = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 8'd0, 0, 0);
  endtask

  task automatic head(input int bp);
    repeat (4) cyc(0, 1, 0, 8'd0, 0, 0);
    idle(bp);
  endtask

  task automatic body(input int nl, input bit alt,
                      input logic [7:0] g,
                      input logic [7:0] thr,
                      input string nm);
    for (int l = 0; l < nl; l++) begin
      repeat (2) cyc(1, 0, 0, 8'd0, 0, 0);
      idle(2);
      for (int p = 0; p < 8; p++) begin
        logic [7:0] px;
        px = alt ? ((p % 2 == 0) ? 8'd255 : 8'd0) : g;
        cyc(0, 0, 1, px, 1, px > thr);
      end
      idle(2);
    end
    idle(4);
    if (nl > 0) check(nm, thr_value, thr);
  endtask

  task automatic frame(input int bp, input int nl,
                       input bit alt, input logic [7:0] g,
                       input logic [7:0] thr,
                       input string nm);
    head(bp);
    body(nl, alt, g, thr, nm);
  endtask

  initial begin
    tv[0]  = '{8'd128, 1'b0, 8'd0,   1'b0};
    tv[1]  = '{8'd129, 1'b0, 8'd0,   1'b1};
    tv[2]  = '{8'd51,  1'b1, 8'd50,  1'b1};
    tv[3]  = '{8'd50,  1'b1, 8'd50,  1'b0};
    tv[4]  = '{8'd129, 1'b0, 8'd0,   1'b1};
    tv[5]  = '{8'd128, 1'b1, 8'd127, 1'b1};
    tv[6]  = '{8'd128, 1'b0, 8'd0,   1'b0};
    tv[7]  = '{8'd0,   1'b0, 8'd0,   1'b0};
    tv[8]  = '{8'd255, 1'b0, 8'd0,   1'b1};
    tv[9]  = '{8'd200, 1'b1, 8'd255, 1'b0};
    tv[10] = '{8'd10,  1'b1, 8'd0,   1'b1};
    tv[11] = '{8'd60,  1'b0, 8'd0,   1'b0};

    rst        = 1'b1;
    in_hs      = 1'b0;
    in_vs      = 1'b0;
    in_de      = 1'b0;
    in_data    = '0;
    thr_mode   = 1'b0;
    thr_manual = '0;
    cur_chk    = 1'b0;
    cur_exp    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hs",   out_hs,    0);
    check("rst_vs",   out_vs,    0);
    check("rst_de",   out_de,    0);
    check("rst_data", out_data,  0);
    check("rst_thr",  thr_value, 128);
    rst = 1'b0;
    idle(3);

    // frame A: mixed pixels, mean = 1268/12 = 105
    head(40);
    repeat (2) cyc(1, 0, 0, 8'd0, 0, 0);
    idle(2);
    for (int i = 0; i < 12; i++) begin
      thr_mode   = tv[i].mode;
      thr_manual = tv[i].man;
      cyc(0, 0, 1, tv[i].g, 1, tv[i].exp_b);
      idle(2);
    end
    thr_mode   = 1'b0;
    thr_manual = '0;
    idle(4);
    check("thr_A", thr_value, 128);

    frame(40, 2, 0, 8'd100, 8'd105, "thr_B");
    frame(40, 2, 0, 8'd100, 8'd100, "thr_C");
    frame(40, 2, 1, 8'd0,   8'd100, "thr_D");
    frame(40, 2, 0, 8'd60,  8'd127, "thr_E");
    frame(40, 0, 0, 8'd0,   8'd0,   "F");
    frame(40, 2, 0, 8'd90,  8'd60,  "thr_G");
    frame(6,  2, 0, 8'd30,  8'd60,  "thr_H");
    frame(6,  2, 0, 8'd170, 8'd90,  "thr_I");
    frame(40, 2, 0, 8'd40,  8'd170, "thr_J");

    // frame K: reset lands mid-divide
    repeat (4) cyc(0, 1, 0, 8'd0, 0, 0);
    idle(6);
    rst = 1'b1;
    idle(3);
    check("rst2_thr",  thr_value, 128);
    check("rst2_de",   out_de,    0);
    check("rst2_data", out_data,  0);
    rst = 1'b0;
    idle(40);
    body(2, 0, 8'd200, 8'd128, "thr_K");
    frame(40, 2, 0, 8'd150, 8'd200, "thr_L");
    idle(5);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
